clb_cfg_writer: RTL and testbench
=================================

# clb_cfg_writer

Serializes one CLB configuration frame onto the configuration AXI-stream and acts as the transmitting end of the CLB config channel. Parallel configuration fields for one CLB go in: per-LUT-input source type, per-LUT-input source index, and the LUT truth table. They leave as a bit-serial frame in exactly the field order and widths the CLB's bitstream readers consume. It sits between the bitstream loader/controller and a CLB's `cfg_bitstream` slave.

## Interface
- `LUT_WIDTH`, default 4: LUT inputs per CLB.
- `BITSTREAM_DATA_WIDTH`, default 1: `tdata` width. Only `tdata[0]` carries the config bit; the upper bits are driven 0.

- `clk`, input, 1: clock.
- `rst`, input, 1: reset. One clock; reset is synchronous and active-high.
- `start`, input, 1: request to send one frame. Sampled only when idle.
- `lut_input_types`, input, `LUT_WIDTH*2`: type of input i is at `[2i+1:2i]`. Encoding: 0 = neighbour, 1 = io, 2 = feedback.
- `lut_input_indices`, input, `LUT_WIDTH*8`: index of input i is at `[8i+7:8i]`.
- `lut_table`, input, `2**LUT_WIDTH`: truth table. Bit k is the output for input vector k.
- `busy`, output, 1: frame in progress.
- `done`, output, 1: one-cycle pulse after the last beat is accepted.
- `cfg_bitstream`, `axi_stream_if.master`, `BITSTREAM_DATA_WIDTH`: `tvalid`, `tdata`, `tlast` out; `tready` in.

## Operation
- **Frame format, LSB-first within every field:**
  - For i = 0..LUT_WIDTH-1: 2 type bits, then 8 index bits.
  - Then `2**LUT_WIDTH` table bits, bit 0 first.
  - Frame length F = LUT_WIDTH*10 + 2**LUT_WIDTH beats; F = 56 for LUT_WIDTH = 4.
- **Index bits are always sent**, including for the feedback type. The receiver always reads the index field.
- **Input capture:** all config inputs are captured into internal registers on the cycle `start` is accepted. Later changes to the inputs have no effect on the frame in flight.
- **FSM states:** IDLE, SEND_TYPE, SEND_INDEX, SEND_TABLE.
  - IDLE → SEND_TYPE on `start`.
  - SEND_TYPE → SEND_INDEX after 2 handshakes.
  - SEND_INDEX → SEND_TYPE for the next input after 8 handshakes. After input LUT_WIDTH-1 it goes to SEND_TABLE instead.
  - SEND_TABLE → IDLE after `2**LUT_WIDTH` handshakes.
- **Counters:**
  - Input counter is `$clog2(LUT_WIDTH)` bits and saturates at LUT_WIDTH-1.
  - Bit counter is wide enough for `2**LUT_WIDTH-1`. It clears on every state change and never wraps inside a field.
- **Handshake:** a beat transfers when `tvalid && tready`.
  - Once `tvalid` is high, `tvalid`, `tdata` and `tlast` hold stable until the transfer.
  - `tvalid` is never withdrawn mid-frame except by reset.
- **`tlast`:** high only on beat F-1 (the final table bit).
- **`start` outside IDLE** is ignored, with no queuing.
- **Reset:** all state is cleared; the FSM goes to IDLE with counters at 0. Reset mid-frame abandons the frame without asserting `tlast`. The next frame starts from beat 0.

## Timing
- Reset values: `tvalid`=0, `tdata`=0, `tlast`=0, `busy`=0, `done`=0.
- All outputs are registered.
- `start` accepted on edge N: `busy` and `tvalid` are high from cycle N+1 with beat 0 on `tdata`.
- With `tready` held high, one beat per cycle: the frame occupies F consecutive cycles.
- Final handshake on edge M:
  - In cycle M+1, `tvalid`, `tlast` and `busy` are 0 and `done` is 1 for exactly one cycle.
  - `start` is accepted in that same cycle, giving a 1-cycle gap between frames.
- `tready` has no combinational path to any output.

## Structure
- **Shared package `clb_cfg_pkg`:** holds the constants and types shared with the CLB side.
  - `SIGNAL_TYPE_W`=2 and `SIGNAL_INDEX_W`=8.
  - The `t_input_type` enum (neighbour, io, feedback).
  - A function `clb_cfg_frame_len(lut_width)` returning F.
- **Sub-module `bitstream_writer #(NUM_BITS_TO_WRITE)`:** the transmit counterpart of the bitstream reader.
  - Loads a word on `start`, shifts it out LSB-first over the stream, and pulses `ready` after the last handshake.
  - Instantiate once each for type, index and table, or once with a muxed load; either is acceptable.

## Test plan
All scenarios use LUT_WIDTH = 4 (F = 56).
1. **Basic frame.**
   - Stimulus: all types = 1 (io); indices 0x03, 0x05, 0x07, 0x09; `lut_table` = 0x8000; `tready`=1.
   - Required: 56 consecutive beats. Beats 0–1 = 1,0; beats 2–9 = 1,1,0,0,0,0,0,0; beats 40–54 = 0; beat 55 = 1 with `tlast`=1. `done` pulses one cycle after beat 55.
2. **Random backpressure.**
   - Stimulus: same frame with `tready` random at 50%.
   - Required: same bit sequence. `tdata`, `tlast` and `tvalid` stable across every stall; `tlast` seen exactly once.
3. **Feedback input with capture check.**
   - Stimulus: input 2 set to type 2 (feedback) with index 0xFF. Change all inputs and pulse `start` again at beat 10.
   - Required: beats 20–21 = 0,1; beats 22–29 all 1. Second `start` ignored; original frame unchanged.
4. **Reset mid-frame.**
   - Stimulus: assert `rst` at beat 20.
   - Required: next cycle `tvalid`=`busy`=`done`=0. A new `start` produces a full 56-beat frame from beat 0.
5. **Back-to-back frames.**
   - Stimulus: `start` held high continuously.
   - Required: frames of 56 beats each, separated by exactly one idle cycle coinciding with `done`=1.
6. **Reset values.**
   - Stimulus: hold `rst` for 3 cycles with `start`=1.
   - Required: all outputs 0 throughout; the first beat appears 2 cycles after `rst` deasserts.

Source files
------------

// File: rtl/clb_cfg_writer_pkg.sv
// clb_cfg_pkg: constants and types shared between the CLB configuration
// writer and the CLB-side bitstream readers.
//   SIGNAL_TYPE_W / SIGNAL_INDEX_W : widths of the per-LUT-input fields
//   t_input_type                   : LUT input source encoding
//   t_cfg_state                    : writer frame sequencer states
//   clb_cfg_frame_len()            : beats in one CLB configuration frame
package clb_cfg_pkg;

    localparam int unsigned SIGNAL_TYPE_W  = 2;
    localparam int unsigned SIGNAL_INDEX_W = 8;

    typedef enum logic [SIGNAL_TYPE_W-1:0] {
        INPUT_NEIGHBOUR = 2'd0,
        INPUT_IO        = 2'd1,
        INPUT_FEEDBACK  = 2'd2
    } t_input_type;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND_TYPE,
        ST_SEND_INDEX,
        ST_SEND_TABLE
    } t_cfg_state;

    function automatic int unsigned clb_cfg_frame_len(input int unsigned lut_width);
        return lut_width * (SIGNAL_TYPE_W + SIGNAL_INDEX_W) + (32'd1 << lut_width);
    endfunction

endpackage

// File: rtl/clb_cfg_writer_if.sv
// axi_stream_if: single-channel AXI-stream bundle for the CLB config channel.
//   tvalid/tdata/tlast : driven by the master
//   tready             : driven by the slave
interface axi_stream_if #(
    parameter int unsigned DATA_WIDTH = 1
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/clb_cfg_writer_bitstream_writer.sv
// bitstream_writer: loads a NUM_BITS_TO_WRITE word on i_start and shifts it
// out LSB-first, one bit per handshake; o_ready pulses the cycle after the
// last handshake.
//   clk, rst          : clock, synchronous active-high reset
//   i_start, i_data   : load request and word to send
//   i_tready          : stream ready from the receiver
//   o_tvalid, o_tdata : registered stream valid / current bit
//   o_ready           : one-cycle pulse after the final bit is accepted
module bitstream_writer #(
    parameter int unsigned NUM_BITS_TO_WRITE = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_start,
    input  logic [NUM_BITS_TO_WRITE-1:0] i_data,
    input  logic                         i_tready,
    output logic                         o_tvalid,
    output logic                         o_tdata,
    output logic                         o_ready
);
    localparam int unsigned CNT_W = (NUM_BITS_TO_WRITE > 1) ? $clog2(NUM_BITS_TO_WRITE) : 1;

    logic [NUM_BITS_TO_WRITE-1:0] r_shift;
    logic [CNT_W-1:0]             r_cnt;
    logic                         r_valid;
    logic                         r_ready;
    logic                         w_hs;
    logic                         w_last_hs;

    assign w_hs      = r_valid && i_tready;
    assign w_last_hs = w_hs && (r_cnt == CNT_W'(NUM_BITS_TO_WRITE - 1));

    // A start coinciding with the final handshake reloads without a bubble,
    // which lets the caller chain fields back-to-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_ready <= w_last_hs;
            if (i_start) begin
                r_shift <= i_data;
                r_cnt   <= '0;
                r_valid <= 1'b1;
            end else if (w_hs) begin
                if (w_last_hs) begin
                    r_valid <= 1'b0;
                end else begin
                    r_shift <= r_shift >> 1;
                    r_cnt   <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign o_tvalid = r_valid;
    assign o_tdata  = r_shift[0];
    assign o_ready  = r_ready;

endmodule

// File: rtl/clb_cfg_writer.sv
// clb_cfg_writer: captures one CLB's parallel configuration and sends it as a
// bit-serial frame: per input {2 type bits, 8 index bits}, then the truth
// table, every field LSB-first.
//   clk, rst          : clock, synchronous active-high reset
//   start             : send request, sampled only when idle
//   lut_input_types   : 2 bits per LUT input
//   lut_input_indices : 8 bits per LUT input
//   lut_table         : truth table, bit k = output for input vector k
//   busy, done        : frame in progress / one-cycle end-of-frame pulse
//   cfg_bitstream     : AXI-stream master, config bit on tdata[0]
module clb_cfg_writer
    import clb_cfg_pkg::*;
#(
    parameter int unsigned LUT_WIDTH            = 4,
    parameter int unsigned BITSTREAM_DATA_WIDTH = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [LUT_WIDTH*SIGNAL_TYPE_W-1:0]  lut_input_types,
    input  logic [LUT_WIDTH*SIGNAL_INDEX_W-1:0] lut_input_indices,
    input  logic [2**LUT_WIDTH-1:0]             lut_table,
    output logic                                busy,
    output logic                                done,
    axi_stream_if.master                        cfg_bitstream
);
    localparam int unsigned TABLE_BITS = 2**LUT_WIDTH;
    localparam int unsigned IN_W       = (LUT_WIDTH > 1) ? $clog2(LUT_WIDTH) : 1;
    // Must also reach SIGNAL_INDEX_W-1 for very small LUTs.
    localparam int unsigned BIT_W      = (LUT_WIDTH > 3) ? LUT_WIDTH : 3;

    t_cfg_state                          r_state;
    t_cfg_state                          w_state_nxt;
    logic [IN_W-1:0]                     r_in_cnt;
    logic [IN_W-1:0]                     w_in_inc;
    logic [BIT_W-1:0]                    r_bit_cnt;
    logic [LUT_WIDTH*SIGNAL_TYPE_W-1:0]  r_types;
    logic [LUT_WIDTH*SIGNAL_INDEX_W-1:0] r_indices;
    logic [TABLE_BITS-1:0]               r_table;

    logic                      w_capture;
    logic                      w_type_start, w_idx_start, w_tbl_start;
    logic [SIGNAL_TYPE_W-1:0]  w_type_load;
    logic [SIGNAL_INDEX_W-1:0] w_idx_load;
    logic                      w_type_v, w_type_d, w_type_rdy;
    logic                      w_idx_v, w_idx_d, w_idx_rdy;
    logic                      w_tbl_v, w_tbl_d, w_tbl_rdy;
    logic                      w_tvalid, w_hs;
    logic [BITSTREAM_DATA_WIDTH-1:0] w_tdata;
    logic                      w_unused_rdy;

    assign w_capture = (r_state == ST_IDLE) && start;
    assign w_in_inc  = r_in_cnt + IN_W'(1);
    assign w_tvalid  = w_type_v | w_idx_v | w_tbl_v;
    assign w_hs      = w_tvalid && cfg_bitstream.tready;
    // Index field base is in_cnt*8; the writers load it at the type->index boundary.
    assign w_idx_load = r_indices[{r_in_cnt, 3'b000} +: SIGNAL_INDEX_W];

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Each field's writer is started on the edge of the previous field's last
    // handshake so the stream never drops tvalid inside a frame.
    always_comb begin
        w_state_nxt  = r_state;
        w_type_start = 1'b0;
        w_idx_start  = 1'b0;
        w_tbl_start  = 1'b0;
        w_type_load  = lut_input_types[SIGNAL_TYPE_W-1:0];
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt  = ST_SEND_TYPE;
                    w_type_start = 1'b1;
                end
            end
            ST_SEND_TYPE: begin
                if (w_hs && r_bit_cnt == BIT_W'(SIGNAL_TYPE_W - 1)) begin
                    w_state_nxt = ST_SEND_INDEX;
                    w_idx_start = 1'b1;
                end
            end
            ST_SEND_INDEX: begin
                if (w_hs && r_bit_cnt == BIT_W'(SIGNAL_INDEX_W - 1)) begin
                    if (r_in_cnt == IN_W'(LUT_WIDTH - 1)) begin
                        w_state_nxt = ST_SEND_TABLE;
                        w_tbl_start = 1'b1;
                    end else begin
                        w_state_nxt  = ST_SEND_TYPE;
                        w_type_start = 1'b1;
                        w_type_load  = r_types[{w_in_inc, 1'b0} +: SIGNAL_TYPE_W];
                    end
                end
            end
            ST_SEND_TABLE: begin
                if (w_hs && r_bit_cnt == BIT_W'(TABLE_BITS - 1)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_cnt  <= '0;
            r_bit_cnt <= '0;
            r_types   <= '0;
            r_indices <= '0;
            r_table   <= '0;
        end else begin
            if (w_state_nxt != r_state) r_bit_cnt <= '0;
            else if (w_hs)              r_bit_cnt <= r_bit_cnt + 1'b1;

            if (w_capture) begin
                r_in_cnt  <= '0;
                r_types   <= lut_input_types;
                r_indices <= lut_input_indices;
                r_table   <= lut_table;
            end else if (r_state == ST_SEND_INDEX && w_state_nxt == ST_SEND_TYPE &&
                         r_in_cnt != IN_W'(LUT_WIDTH - 1)) begin
                r_in_cnt <= w_in_inc;
            end
        end
    end

    bitstream_writer #(.NUM_BITS_TO_WRITE(SIGNAL_TYPE_W)) u_type_writer (
        .clk(clk), .rst(rst), .i_start(w_type_start), .i_data(w_type_load),
        .i_tready(cfg_bitstream.tready), .o_tvalid(w_type_v), .o_tdata(w_type_d),
        .o_ready(w_type_rdy)
    );

    bitstream_writer #(.NUM_BITS_TO_WRITE(SIGNAL_INDEX_W)) u_index_writer (
        .clk(clk), .rst(rst), .i_start(w_idx_start), .i_data(w_idx_load),
        .i_tready(cfg_bitstream.tready), .o_tvalid(w_idx_v), .o_tdata(w_idx_d),
        .o_ready(w_idx_rdy)
    );

    bitstream_writer #(.NUM_BITS_TO_WRITE(TABLE_BITS)) u_table_writer (
        .clk(clk), .rst(rst), .i_start(w_tbl_start), .i_data(r_table),
        .i_tready(cfg_bitstream.tready), .o_tvalid(w_tbl_v), .o_tdata(w_tbl_d),
        .o_ready(w_tbl_rdy)
    );

    // Only one writer is valid at a time; an idle writer's stale shift
    // contents are masked off.
    always_comb begin
        w_tdata    = '0;
        w_tdata[0] = (w_type_v & w_type_d) | (w_idx_v & w_idx_d) | (w_tbl_v & w_tbl_d);
    end

    assign w_unused_rdy = w_type_rdy ^ w_idx_rdy;

    assign cfg_bitstream.tvalid = w_tvalid;
    assign cfg_bitstream.tdata  = w_tdata;
    assign cfg_bitstream.tlast  = (r_state == ST_SEND_TABLE) &&
                                  (r_bit_cnt == BIT_W'(TABLE_BITS - 1));
    assign busy = (r_state != ST_IDLE);
    assign done = w_tbl_rdy;

endmodule

// File: tb/tb_clb_cfg_writer.sv
module tb_clb_cfg_writer;
    import clb_cfg_pkg::*;

    localparam int unsigned LW = 4;
    localparam int          F  = 56;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  types;
    logic [31:0] indices;
    logic [15:0] table_v;
    logic        busy;
    logic        done;

    axi_stream_if #(.DATA_WIDTH(1)) s_axis ();

    clb_cfg_writer #(.LUT_WIDTH(LW), .BITSTREAM_DATA_WIDTH(1)) dut (
        .clk(clk), .rst(rst), .start(start),
        .lut_input_types(types), .lut_input_indices(indices), .lut_table(table_v),
        .busy(busy), .done(done), .cfg_bitstream(s_axis)
    );

    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    bit   exp_q[$];
    logic got_q[$];
    int   lasts, last_pos, stall_err, busy_err, gap_cycles;
    bit   timed_out, done_ok, done_once;

    // Reference frame built straight from the field rules.
    function automatic void build_expected(input logic [7:0] t, input logic [31:0] ix,
                                           input logic [15:0] tb);
        exp_q.delete();
        for (int i = 0; i < int'(LW); i++) begin
            for (int b = 0; b < 2; b++) exp_q.push_back(bit'((t >> (2 * i + b)) & 1));
            for (int b = 0; b < 8; b++) exp_q.push_back(bit'((ix >> (8 * i + b)) & 1));
        end
        for (int k = 0; k < 16; k++) exp_q.push_back(bit'((tb >> k) & 1));
    endfunction

    function automatic int frame_diff();
        int n = 0;
        if (got_q.size() != exp_q.size()) return 1000;
        foreach (got_q[i]) if (got_q[i] !== exp_q[i]) n++;
        return n;
    endfunction

    task automatic random_inputs();
        for (int i = 0; i < int'(LW); i++) types[2*i +: 2] = 2'($urandom_range(2));
        indices = $urandom;
        table_v = 16'($urandom);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Collects F accepted beats, tracking stall stability, busy and tlast.
    task automatic capture(input int pct, input int poke_beat, input int budget);
        logic v, d, l, rdy, pd, pl;
        bit   stalled, poked;
        got_q.delete();
        lasts = 0; last_pos = -1; stall_err = 0; busy_err = 0; gap_cycles = 0;
        timed_out = 1; stalled = 0; poked = 0; pd = 0; pl = 0;
        for (int c = 0; c < budget; c++) begin
            if (stalled && (s_axis.tvalid !== 1'b1 || s_axis.tdata[0] !== pd ||
                            s_axis.tlast !== pl)) stall_err++;
            if (busy !== 1'b1) busy_err++;
            start = 1'b0;
            if (poke_beat >= 0 && got_q.size() == poke_beat && !poked) begin
                poked = 1;
                start = 1'b1;
                types = 8'($urandom); indices = $urandom; table_v = 16'($urandom);
            end
            rdy = (pct >= 100) ? 1'b1 : ($urandom_range(99) < pct);
            s_axis.tready = rdy;
            v = s_axis.tvalid; d = s_axis.tdata[0]; l = s_axis.tlast;
            if (v !== 1'b1) gap_cycles++;
            @(posedge clk); #1;
            stalled = (v === 1'b1) && !rdy;
            pd = d; pl = l;
            if (v === 1'b1 && rdy) begin
                got_q.push_back(d);
                if (l === 1'b1) begin lasts++; last_pos = got_q.size() - 1; end
                if (got_q.size() == F) begin timed_out = 0; break; end
            end
        end
        start = 1'b0;
        done_ok = (done === 1'b1 && s_axis.tvalid === 1'b0 && s_axis.tlast === 1'b0 &&
                   busy === 1'b0);
        @(posedge clk); #1;
        done_once = (done === 1'b0);
    endtask

    task automatic test_reset();
        int err = 0;
        rst = 1'b1; start = 1'b1; s_axis.tready = 1'b1;
        random_inputs();
        build_expected(types, indices, table_v);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            n_tests++;
            if (s_axis.tvalid !== 1'b0 || s_axis.tdata !== 1'b0 || s_axis.tlast !== 1'b0 ||
                busy !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_values cycle %0d: tvalid=%b tdata=%b tlast=%b busy=%b done=%b, need all 0",
                         c, s_axis.tvalid, s_axis.tdata, s_axis.tlast, busy, done);
            end
        end
        rst = 1'b0;
        n_tests++;
        if (s_axis.tvalid !== 1'b0) begin
            n_fail++; err++;
            $display("FAIL reset_release_cycle1: tvalid=%b, need 0", s_axis.tvalid);
        end
        @(posedge clk); #1;
        start = 1'b0;
        n_tests++;
        if (s_axis.tvalid !== 1'b1 || s_axis.tdata[0] !== exp_q[0]) begin
            n_fail++;
            $display("FAIL reset_release_cycle2: tvalid=%b tdata=%b, need 1 and %b",
                     s_axis.tvalid, s_axis.tdata[0], exp_q[0]);
        end
        capture(100, -1, 4 * F);
        n_tests++;
        if (timed_out || frame_diff() != 0) begin
            n_fail++;
            $display("FAIL reset_first_frame: %0d beats %0d diffs, need %0d beats 0 diffs",
                     got_q.size(), frame_diff(), F);
        end
    endtask

    task automatic test_basic();
        logic [9:0] first10;
        int tail_err = 0;
        types = 8'h55; indices = 32'h0907_0503; table_v = 16'h8000;
        build_expected(types, indices, table_v);
        s_axis.tready = 1'b1;
        do_start();
        n_tests++;
        if (s_axis.tvalid !== 1'b1 || busy !== 1'b1 || s_axis.tdata[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_first_beat: tvalid=%b busy=%b tdata=%b, need 1 1 1",
                     s_axis.tvalid, busy, s_axis.tdata[0]);
        end
        capture(100, -1, 4 * F);
        n_tests++;
        if (timed_out || frame_diff() != 0) begin
            n_fail++;
            $display("FAIL basic_frame: %0d beats %0d diffs, need %0d beats 0 diffs",
                     got_q.size(), frame_diff(), F);
        end
        if (got_q.size() == F) begin
            for (int i = 0; i < 10; i++) first10[i] = got_q[i];
            for (int i = 40; i < 55; i++) if (got_q[i] !== 1'b0) tail_err++;
            if (got_q[55] !== 1'b1) tail_err++;
        end else begin
            first10 = 'x; tail_err = 99;
        end
        n_tests++;
        if (first10 !== 10'b00_0000_1101) begin
            n_fail++;
            $display("FAIL basic_first10: got %b, need 0000001101", first10);
        end
        n_tests++;
        if (tail_err != 0) begin
            n_fail++;
            $display("FAIL basic_table_bits: %0d wrong in beats 40..55, need 0", tail_err);
        end
        n_tests++;
        if (gap_cycles != 0 || lasts != 1 || last_pos != F - 1) begin
            n_fail++;
            $display("FAIL basic_timing: gaps=%0d tlast_count=%0d tlast_pos=%0d, need 0 1 %0d",
                     gap_cycles, lasts, last_pos, F - 1);
        end
        n_tests++;
        if (!done_ok || !done_once) begin
            n_fail++;
            $display("FAIL basic_done: done_cycle_ok=%0d done_cleared=%0d, need 1 1",
                     done_ok, done_once);
        end
    endtask

    task automatic test_backpressure();
        types = 8'h55; indices = 32'h0907_0503; table_v = 16'h8000;
        build_expected(types, indices, table_v);
        s_axis.tready = 1'b0;
        do_start();
        capture(50, -1, 20 * F);
        n_tests++;
        if (timed_out || frame_diff() != 0) begin
            n_fail++;
            $display("FAIL backpressure_frame: %0d beats %0d diffs, need %0d beats 0 diffs",
                     got_q.size(), frame_diff(), F);
        end
        n_tests++;
        if (stall_err != 0 || busy_err != 0 || lasts != 1 || last_pos != F - 1) begin
            n_fail++;
            $display("FAIL backpressure_stable: stall_err=%0d busy_err=%0d tlast_count=%0d pos=%0d, need 0 0 1 %0d",
                     stall_err, busy_err, lasts, last_pos, F - 1);
        end
    endtask

    task automatic test_feedback_capture();
        int spot_err = 0;
        random_inputs();
        types[5:4]    = INPUT_FEEDBACK;
        indices[23:16] = 8'hFF;
        build_expected(types, indices, table_v);
        s_axis.tready = 1'b1;
        do_start();
        capture(100, 10, 4 * F);
        n_tests++;
        if (timed_out || frame_diff() != 0) begin
            n_fail++;
            $display("FAIL feedback_frame: %0d beats %0d diffs, need %0d beats 0 diffs",
                     got_q.size(), frame_diff(), F);
        end
        if (got_q.size() == F) begin
            if (got_q[20] !== 1'b0 || got_q[21] !== 1'b1) spot_err++;
            for (int i = 22; i < 30; i++) if (got_q[i] !== 1'b1) spot_err++;
        end else spot_err = 99;
        n_tests++;
        if (spot_err != 0) begin
            n_fail++;
            $display("FAIL feedback_fields: %0d wrong in beats 20..29, need 0", spot_err);
        end
        n_tests++;
        if (!done_ok || !done_once || s_axis.tvalid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL feedback_second_start: done_ok=%0d tvalid=%b busy=%b, need 1 0 0",
                     done_ok, s_axis.tvalid, busy);
        end
    endtask

    task automatic test_reset_midframe();
        random_inputs();
        s_axis.tready = 1'b1;
        do_start();
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_tests++;
        if (s_axis.tvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || s_axis.tlast !== 1'b0) begin
            n_fail++;
            $display("FAIL midframe_reset: tvalid=%b busy=%b done=%b tlast=%b, need 0 0 0 0",
                     s_axis.tvalid, busy, done, s_axis.tlast);
        end
        random_inputs();
        build_expected(types, indices, table_v);
        do_start();
        capture(100, -1, 4 * F);
        n_tests++;
        if (timed_out || frame_diff() != 0 || lasts != 1) begin
            n_fail++;
            $display("FAIL midframe_restart: %0d beats %0d diffs tlast_count=%0d, need %0d 0 1",
                     got_q.size(), frame_diff(), lasts, F);
        end
    endtask

    task automatic test_back_to_back();
        int vd_err = 0, data_err = 0, last_err = 0;
        random_inputs();
        build_expected(types, indices, table_v);
        s_axis.tready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 3 * (F + 1); c++) begin
            int p;
            bit ev;
            p  = c % (F + 1);
            ev = (p != F);
            if (s_axis.tvalid !== ev || done !== !ev) vd_err++;
            if (ev && s_axis.tdata[0] !== exp_q[p]) data_err++;
            if (s_axis.tlast !== (ev && p == F - 1)) last_err++;
            @(posedge clk); #1;
        end
        start = 1'b0;
        n_tests++;
        if (vd_err != 0) begin
            n_fail++;
            $display("FAIL b2b_spacing: %0d cycles with wrong tvalid/done, need 0", vd_err);
        end
        n_tests++;
        if (data_err != 0 || last_err != 0) begin
            n_fail++;
            $display("FAIL b2b_data: data_err=%0d tlast_err=%0d, need 0 0", data_err, last_err);
        end
        capture(100, -1, 4 * F);
        n_tests++;
        if (timed_out || frame_diff() != 0) begin
            n_fail++;
            $display("FAIL b2b_last_frame: %0d beats %0d diffs, need %0d 0", got_q.size(), frame_diff(), F);
        end
    endtask

    task automatic test_random_frames();
        for (int it = 0; it < 4; it++) begin
            int pct;
            pct = 30 + int'($urandom_range(70));
            types = 8'($urandom);
            indices = $urandom;
            table_v = 16'($urandom);
            build_expected(types, indices, table_v);
            s_axis.tready = 1'b0;
            do_start();
            capture(pct, -1, 20 * F);
            n_tests++;
            if (timed_out || frame_diff() != 0 || stall_err != 0 || busy_err != 0 ||
                lasts != 1 || !done_ok || !done_once) begin
                n_fail++;
                $display("FAIL random_frame%0d: beats=%0d diffs=%0d stall=%0d busy=%0d tlast=%0d done=%0d/%0d, need %0d 0 0 0 1 1/1",
                         it, got_q.size(), frame_diff(), stall_err, busy_err, lasts,
                         done_ok, done_once, F);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; s_axis.tready = 1'b0;
        types = '0; indices = '0; table_v = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_feedback_capture();
        test_reset_midframe();
        test_back_to_back();
        test_random_frames();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1);
    end

endmodule
